// File: rtl/alu_shift_issue_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_shift_issue_if
//  Purpose  : Bundles the operand handshake, the shifter-facing signals and
//             the result handshake of the issue stage.
//  Modports : slave  - issue stage (accepts operands, drives shifter inputs,
//                      presents results)
//             master - environment (upstream producer, shifter, downstream
//                      consumer)
//  Signals  : in_valid/in_ready/in_a/in_b      operand handshake
//             shf_a/shf_b/shf_out              shifter connection
//             out_valid/out_ready/out_data/
//             out_z/out_n/out_c                result handshake and flags
//  Revision : 1.0  initial release
// ============================================================================
interface alu_shift_issue_if #(
    parameter int NBITS = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [NBITS-1:0] in_a;
    logic [NBITS-1:0] in_b;
    logic [NBITS-1:0] shf_a;
    logic [NBITS-1:0] shf_b;
    logic [NBITS-1:0] shf_out;
    logic             out_valid;
    logic             out_ready;
    logic [NBITS-1:0] out_data;
    logic             out_z;
    logic             out_n;
    logic             out_c;

    modport slave (
        input  in_valid, in_a, in_b, shf_out, out_ready,
        output in_ready, shf_a, shf_b, out_valid, out_data, out_z, out_n, out_c
    );

    modport master (
        output in_valid, in_a, in_b, shf_out, out_ready,
        input  in_ready, shf_a, shf_b, out_valid, out_data, out_z, out_n, out_c
    );
endinterface
`default_nettype wire

// File: rtl/alu_shift_issue.sv
`default_nettype none
// ============================================================================
//  Module   : alu_shift_issue
//  Purpose  : Pipelined, back-pressurable issue wrapper around a combinational
//             left-logical barrel shifter. Operands are registered onto the
//             shifter inputs; the result plus Z/N (optional C) flags is
//             captured into a 2-entry output buffer. Sustains 1 op/cycle.
//  Ports    : clk    - clock, rising edge
//             rst_n  - asynchronous active-low reset
//             bus    - alu_shift_issue_if.slave (operand handshake, shifter
//                      inputs/result, result handshake with flags)
//  Options  : SHIFT_CARRY_EN - when defined, the last bit shifted out is
//             stored per buffer entry and presented on out_c; otherwise
//             out_c is tied low.
//  Revision : 1.0  initial release
// ============================================================================
module alu_shift_issue #(
    parameter int NBITS = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    alu_shift_issue_if.slave  bus
);

    // State summarises {op_v, count}; S_STALL means an operand is held and
    // the buffer is full, so it can only move if the head is popped.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_op_v;
    logic [NBITS-1:0] r_shf_a;
    logic [NBITS-1:0] r_shf_b;
    logic [1:0]       r_count;
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [NBITS-1:0] r_buf_data [2];
    logic [1:0]       r_buf_z;
    logic [1:0]       r_buf_n;

    logic             w_pop;
    logic             w_xfer;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_op_v_nxt;
    logic [1:0]       w_count_nxt;
    logic             w_z;
    logic             w_n;

    assign w_pop      = (r_count != 2'd0) & bus.out_ready;
    // Outside S_STALL a held operand always has a free slot.
    assign w_xfer     = r_op_v & ((r_state != S_STALL) | w_pop);
    assign w_in_ready = ~r_op_v | w_xfer;
    assign w_accept   = bus.in_valid & w_in_ready;

    assign w_z = (bus.shf_out == '0);
    assign w_n = bus.shf_out[NBITS-1];

    always_comb begin
        w_op_v_nxt  = r_op_v;
        w_count_nxt = r_count;
        w_state_nxt = S_RUN;
        if (w_accept) begin
            w_op_v_nxt = 1'b1;
        end else if (w_xfer) begin
            w_op_v_nxt = 1'b0;
        end
        case ({w_xfer, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
        if (!w_op_v_nxt && (w_count_nxt == 2'd0)) begin
            w_state_nxt = S_IDLE;
        end else if (w_op_v_nxt && (w_count_nxt == 2'd2)) begin
            w_state_nxt = S_STALL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op_v   <= 1'b0;
            r_shf_a  <= '0;
            r_shf_b  <= '0;
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_buf_z  <= 2'b00;
            r_buf_n  <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_buf_data[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_op_v  <= w_op_v_nxt;
            r_count <= w_count_nxt;
            if (w_accept) begin
                r_shf_a <= bus.in_a;
                r_shf_b <= bus.in_b;
            end
            if (w_xfer) begin
                r_buf_data[r_wr_ptr] <= bus.shf_out;
                r_buf_z[r_wr_ptr]    <= w_z;
                r_buf_n[r_wr_ptr]    <= w_n;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

`ifdef SHIFT_CARRY_EN
    logic [1:0] r_buf_c;
    logic       w_carry;

    // Last bit shifted out is A[NBITS-B] for 1 <= B <= NBITS; zero otherwise.
    always_comb begin
        w_carry = 1'b0;
        for (int i = 1; i <= NBITS; i++) begin
            if (int'(r_shf_b) == i) begin
                w_carry = r_shf_a[NBITS-i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_c <= 2'b00;
        end else if (w_xfer) begin
            r_buf_c[r_wr_ptr] <= w_carry;
        end
    end

    assign bus.out_c = r_buf_c[r_rd_ptr];
`else
    assign bus.out_c = 1'b0;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.shf_a     = r_shf_a;
    assign bus.shf_b     = r_shf_b;
    assign bus.out_valid = (r_count != 2'd0);
    assign bus.out_data  = r_buf_data[r_rd_ptr];
    assign bus.out_z     = r_buf_z[r_rd_ptr];
    assign bus.out_n     = r_buf_n[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_alu_shift_issue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_shift_issue
//  Purpose  : Self-checking bench for alu_shift_issue. Provides the
//             combinational shifter, drives directed and random operand /
//             back-pressure traffic, and compares against an in-order
//             result queue plus an occupancy model of the pipeline.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_shift_issue;

    localparam int NBITS = 4;

    typedef struct {
        logic [NBITS-1:0] d;
        logic             z;
        logic             n;
        logic             c;
    } exp_t;

    logic clk;
    logic rst_n;

    alu_shift_issue_if #(.NBITS(NBITS)) bus ();

    alu_shift_issue #(.NBITS(NBITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Left-logical barrel shifter; amounts >= NBITS give zero.
    assign bus.shf_out = (int'(bus.shf_b) >= NBITS) ? '0 : (bus.shf_a << bus.shf_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t q[$];
    int   mbuf        = 0;   // results sitting in the output buffer
    bit   mheld       = 0;   // operand held on the shifter inputs
    logic [NBITS-1:0] last_a = '0;
    logic [NBITS-1:0] last_b = '0;

    function automatic exp_t ref_shift(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b);
        exp_t        r;
        logic [31:0] w;
        w   = 32'(a) << b;
        r.d = w[NBITS-1:0];
        r.z = (r.d == '0);
        r.n = r.d[NBITS-1];
`ifdef SHIFT_CARRY_EN
        r.c = w[NBITS];
`else
        r.c = 1'b0;
`endif
        return r;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [NBITS-1:0] obs, input logic [NBITS-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, update the model, and return
    // at 1 time unit after the following rising edge.
    task automatic tick(output bit acc);
        bit   e_pop, e_xfer, e_rdy;
        exp_t e;
        @(negedge clk);
        e_pop  = (mbuf > 0) && bus.out_ready;
        e_xfer = mheld && ((mbuf < 2) || e_pop);
        e_rdy  = !mheld || e_xfer;
        chk1("out_valid", bus.out_valid, mbuf > 0);
        chk1("in_ready", bus.in_ready, e_rdy);
        if (mheld) begin
            chkd("shf_a", bus.shf_a, last_a);
            chkd("shf_b", bus.shf_b, last_b);
        end
        if (mbuf > 0) begin
            e = q[0];
            chkd("out_data", bus.out_data, e.d);
            chk1("out_z", bus.out_z, e.z);
            chk1("out_n", bus.out_n, e.n);
            chk1("out_c", bus.out_c, e.c);
            if (e_pop) void'(q.pop_front());
        end
        acc = bus.in_valid && bus.in_ready;
        if (acc) begin
            q.push_back(ref_shift(bus.in_a, bus.in_b));
            last_a = bus.in_a;
            last_b = bus.in_b;
        end
        mbuf  = mbuf + int'(e_xfer) - int'(e_pop);
        mheld = acc ? 1'b1 : (e_xfer ? 1'b0 : mheld);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc;
        int n;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        #2;
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chk1("rst_in_ready", bus.in_ready, 1'b1);
        chkd("rst_shf_a", bus.shf_a, '0);
        chkd("rst_shf_b", bus.shf_b, '0);
        chkd("rst_out_data", bus.out_data, '0);
        chk1("rst_out_z", bus.out_z, 1'b0);
        chk1("rst_out_n", bus.out_n, 1'b0);
        chk1("rst_out_c", bus.out_c, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single op: 0011 << 1 = 0110, result visible one cycle after accept.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1; bus.in_a = 4'b0011; bus.in_b = 4'd1;
        tick(acc);
        bus.in_valid  = 1'b0;
        tick(acc);
        chk1("single_valid", bus.out_valid, 1'b1);
        chkd("single_data", bus.out_data, 4'b0110);
        chk1("single_z", bus.out_z, 1'b0);
        chk1("single_n", bus.out_n, 1'b0);
        chk1("single_c", bus.out_c, 1'b0);
        tick(acc);

        // Overshift: 1111 << 4 = 0, Z=1, C=1 only with carry enabled.
        bus.in_valid = 1'b1; bus.in_a = 4'b1111; bus.in_b = 4'd4;
        tick(acc);
        bus.in_valid = 1'b0;
        tick(acc);
        chkd("over_data", bus.out_data, 4'b0000);
        chk1("over_z", bus.out_z, 1'b1);
`ifdef SHIFT_CARRY_EN
        chk1("over_c", bus.out_c, 1'b1);
`else
        chk1("over_c", bus.out_c, 1'b0);
`endif
        tick(acc);

        // Backpressure: four ops offered, only three fit.
        bus.out_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = (n < 4);
            bus.in_a = 4'($urandom_range(0, 15));
            bus.in_b = 4'($urandom_range(0, 7));
            tick(acc);
            if (acc) n++;
        end
        chkd("bp_accepted", 4'(n), 4'd3);
        chk1("bp_in_ready", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        while (n < 4) begin
            tick(acc);
            if (acc) n++;
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick(acc);

        // Streaming: B = 0..7, A = 1001, one accept per cycle.
        n = 0;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1; bus.in_a = 4'b1001; bus.in_b = 4'(i);
            tick(acc);
            if (acc) n++;
        end
        chkd("stream_accepts", 4'(n), 4'd8);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick(acc);

        // Fill to count==2 with one held, then push and pop together.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a = 4'($urandom_range(0, 15));
            bus.in_b = 4'($urandom_range(0, 15));
            tick(acc);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in_a = 4'($urandom_range(0, 15));
            bus.in_b = 4'($urandom_range(0, 15));
            tick(acc);
        end

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.in_a = 4'($urandom_range(0, 15));
            bus.in_b = 4'($urandom_range(0, 15));
            tick(acc);
        end

        // Reset with two buffered and one held.
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick(acc);
        bus.out_ready = 1'b0;
        n = 0;
        while (n < 3) begin
            bus.in_valid = 1'b1;
            bus.in_a = 4'($urandom_range(0, 15));
            bus.in_b = 4'($urandom_range(0, 3));
            tick(acc);
            if (acc) n++;
        end
        bus.in_valid = 1'b0;
        tick(acc);
        chk1("pre_rst_in_ready", bus.in_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_out_valid", bus.out_valid, 1'b0);
        chk1("mid_rst_in_ready", bus.in_ready, 1'b1);
        chkd("mid_rst_shf_a", bus.shf_a, '0);
        q.delete();
        mbuf  = 0;
        mheld = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_a = 4'b0101; bus.in_b = 4'd2;
        tick(acc);
        bus.in_valid = 1'b0;
        tick(acc);
        chkd("post_rst_data", bus.out_data, 4'b0100);
        chk1("post_rst_valid", bus.out_valid, 1'b1);
        for (int i = 0; i < 4; i++) tick(acc);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_shift_issue.md
Name: alu_shift_issue

Overview:
- Sequential wrapper that feeds and consumes the ALU's combinational left-logical barrel shifter.
- Accepts operand pairs over a valid/ready handshake and registers them onto the shifter inputs.
- Captures the shifter result, with Z/N (optional C) flags, into a 2-entry output buffer.
- Gives the ALU datapath a pipelined, back-pressurable shift path at 1 op/cycle.

Parameters:
- Nbits, 4, datapath width of operands, shift amount and result; must equal the shifter's Nbits.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- IN_VALID  input  1  upstream presents an operand pair.
- IN_READY  output  1  block accepts the pair this cycle.
- IN_A  input  Nbits  value to shift.
- IN_B  input  Nbits  shift amount (unsigned, full Nbits width).
- SHF_A  output  Nbits  registered operand A to the shifter's A input.
- SHF_B  output  Nbits  registered operand B to the shifter's B input.
- SHF_OUT  input  Nbits  shifter result (combinational from SHF_A/SHF_B).
- OUT_VALID  output  1  buffer head holds a result.
- OUT_READY  input  1  downstream takes the head.
- OUT_DATA  output  Nbits  result at buffer head.
- OUT_Z  output  1  result == 0.
- OUT_N  output  1  result MSB.
- OUT_C  output  1  carry (last bit shifted out); see Optional Feature.

Behaviour:
- Reset (async assert, sync-free deassert): op_v=0, SHF_A=SHF_B=0, buffer count=0, rd/wr pointers=0, all OUT_* = 0, IN_READY=1.
- Reset mid-operation discards the held operand and all buffered results; no output handshake completes.
- Stage 1 (operand reg, op_v):
  - accept = IN_VALID & IN_READY.
  - On accept: SHF_A<=IN_A, SHF_B<=IN_B, op_v<=1.
  - Else if a transfer occurs: op_v<=0.
- Transfer = op_v & (count<2 | (OUT_VALID & OUT_READY)).
- On transfer: write {SHF_OUT, Z, N, C} to buffer[wr_ptr]; wr_ptr wraps 1->0.
- IN_READY = !op_v | transfer. Combinational from OUT_READY; no path from IN_VALID.
- Output buffer: 2 entries, 1-bit pointers, count 0..2.
  - pop = OUT_VALID & OUT_READY; rd_ptr wraps.
  - OUT_VALID = (count != 0). OUT_* are driven from buffer[rd_ptr] and held stable while OUT_VALID & !OUT_READY.
  - Simultaneous transfer and pop: count unchanged, both pointers advance.
  - Full (count==2) with no pop: transfer blocked, op_v holds, SHF_A/SHF_B stable, IN_READY=0.
  - Empty: OUT_VALID=0; OUT_DATA is don't-care but must not be X after reset.
- FSM derived from {op_v, count}:
  - IDLE (op_v=0, count=0).
  - RUN (op_v=1, count<2, or op_v=0 with count>0).
  - STALL (op_v=1, count=2, no pop).
  - Any state returns to IDLE after the last pop with no new accept.
- Latency: accept at edge k gives OUT_VALID=1 after edge k+1 (when the buffer is not full).
- Throughput: 1 op/cycle while OUT_READY=1.
- Flags: Z=(SHF_OUT==0); N=SHF_OUT[Nbits-1].
- Shift amounts >= Nbits are legal; the shifter returns 0, so Z=1.

Optional Feature:
- Macro: SHIFT_CARRY_EN.
- Defined: C = SHF_A[Nbits-SHF_B] when 1<=SHF_B<=Nbits, else 0. It is stored per buffer entry and presented on OUT_C.
- Undefined: no carry storage; OUT_C tied 0. All other timing is identical.

Test Plan:
- Single op, Nbits=4: A=4'b0011, B=1, OUT_READY=1 -> OUT_VALID one cycle after accept, OUT_DATA=4'b0110, Z=0, N=0, C=0.
- Overshift: A=4'b1111, B=4 -> OUT_DATA=0, Z=1, N=0; with SHIFT_CARRY_EN, C=1.
- Backpressure: OUT_READY=0, push 4 ops -> 3 accepted (2 buffered + 1 held), IN_READY=0, SHF_A/SHF_B stable. Release OUT_READY -> results drain in order with no loss or duplication.
- Streaming: IN_VALID=1 and OUT_READY=1 for 8 cycles with B=0..7, A=4'b1001 -> 8 results back-to-back, each matching the reference model; no bubbles.
- Simultaneous push/pop at count==2: count stays 2, pointers wrap correctly, data order preserved.
- Async reset asserted mid-stream with 2 buffered and 1 held -> OUT_VALID=0 immediately, IN_READY=1 after release, and the next op produces a correct result.
